// File: rtl/seven_seg_pkg.sv
// Shared types and segment constants for the seven-segment scan driver.
// Optional build macro: SEVSEG_DP_EN adds a per-digit decimal-point input.
package seven_seg_pkg;

  localparam int unsigned BRIGHT_W = 4;

  // Cathode pattern {dp,g,f,e,d,c,b,a}, active-low
  typedef logic [7:0] seg_t;

  localparam seg_t SEG_0   = 8'hC0;
  localparam seg_t SEG_1   = 8'hF9;
  localparam seg_t SEG_2   = 8'hA4;
  localparam seg_t SEG_3   = 8'hB0;
  localparam seg_t SEG_4   = 8'h99;
  localparam seg_t SEG_5   = 8'h92;
  localparam seg_t SEG_6   = 8'h82;
  localparam seg_t SEG_7   = 8'hF8;
  localparam seg_t SEG_8   = 8'h80;
  localparam seg_t SEG_9   = 8'h90;
  localparam seg_t SEG_A   = 8'h88;
  localparam seg_t SEG_B   = 8'h83;
  localparam seg_t SEG_C   = 8'hC6;
  localparam seg_t SEG_D   = 8'hA1;
  localparam seg_t SEG_E   = 8'h86;
  localparam seg_t SEG_F   = 8'h8E;
  localparam seg_t SEG_OFF = 8'hFF;

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational hex nibble to active-low segment pattern (dp bit left off).
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg_c
);

  // Full hex table, dp always off
  always_comb begin
    seg_c = SEG_OFF;
    case (nibble)
      4'h0: seg_c = SEG_0;
      4'h1: seg_c = SEG_1;
      4'h2: seg_c = SEG_2;
      4'h3: seg_c = SEG_3;
      4'h4: seg_c = SEG_4;
      4'h5: seg_c = SEG_5;
      4'h6: seg_c = SEG_6;
      4'h7: seg_c = SEG_7;
      4'h8: seg_c = SEG_8;
      4'h9: seg_c = SEG_9;
      4'hA: seg_c = SEG_A;
      4'hB: seg_c = SEG_B;
      4'hC: seg_c = SEG_C;
      4'hD: seg_c = SEG_D;
      4'hE: seg_c = SEG_E;
      4'hF: seg_c = SEG_F;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with per-digit blanking,
// 16-level PWM brightness and frame-synchronous (tear-free) data updates.
// Optional build macro: SEVSEG_DP_EN adds input dp[N_DIGITS-1:0].
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int unsigned N_DIGITS = 8,
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]   blank_mask,
`ifdef SEVSEG_DP_EN
  input  logic [N_DIGITS-1:0]   dp,
`endif
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [N_DIGITS-1:0]   an,
  output seg_t                  cathode,
  output logic                  frame_start
);

  localparam int unsigned PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned THR_W   = PRESC_W + 1;
  localparam int unsigned IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned DIG_W   = 4 * N_DIGITS;

  logic [PRESC_W-1:0]  presc, presc_nxt;
  logic [IDX_W-1:0]    idx, idx_nxt;
  logic [BRIGHT_W-1:0] bright_q;
  logic [DIG_W-1:0]    shadow_digits, active_digits;
  logic [N_DIGITS-1:0] shadow_mask, active_mask;
  logic                pending;

  logic                slot_end_c, frame_end_c, blank_c, dp_bit_c;
  logic [3:0]          nib_c;
  logic [THR_W-1:0]    thr_c;
  seg_t                seg_c, cathode_nxt;
  logic [N_DIGITS-1:0] an_nxt;

  // Slot / frame boundary detection and counter next-state
  always_comb begin
    slot_end_c  = (presc == PRESC_W'(SCAN_DIV - 1));
    frame_end_c = slot_end_c && (idx == IDX_W'(N_DIGITS - 1));
    presc_nxt   = presc + PRESC_W'(1);
    idx_nxt     = idx;
    if (slot_end_c) begin
      presc_nxt = '0;
      idx_nxt   = frame_end_c ? '0 : idx + IDX_W'(1);
    end
  end

  // Prescaler, digit index, frame pulse; brightness latched once per slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc       <= '0;
      idx         <= '0;
      frame_start <= 1'b0;
      bright_q    <= '0;
    end else begin
      presc       <= presc_nxt;
      idx         <= idx_nxt;
      frame_start <= frame_end_c;
      if (presc == '0) bright_q <= brightness;
    end
  end

  // Shadow capture on load; active swaps only at frame wrap (wrap-cycle load bypasses shadow)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_digits <= '0;
      shadow_mask   <= '0;
      active_digits <= '0;
      active_mask   <= '0;
      pending       <= 1'b0;
    end else begin
      if (load) begin
        shadow_digits <= digits;
        shadow_mask   <= blank_mask;
      end
      if (frame_end_c) begin
        pending <= 1'b0;
        if (load) begin
          active_digits <= digits;
          active_mask   <= blank_mask;
        end else if (pending) begin
          active_digits <= shadow_digits;
          active_mask   <= shadow_mask;
        end
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

`ifdef SEVSEG_DP_EN
  logic [N_DIGITS-1:0] shadow_dp, active_dp;

  // Decimal points follow the same shadow/active path as the digit data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_dp <= '0;
      active_dp <= '0;
    end else begin
      if (load) shadow_dp <= dp;
      if (frame_end_c) begin
        if (load)         active_dp <= dp;
        else if (pending) active_dp <= shadow_dp;
      end
    end
  end

  assign dp_bit_c = ~(1'(active_dp >> idx));
`else
  assign dp_bit_c = 1'b1;
`endif

  assign nib_c   = 4'(active_digits >> {idx, 2'b00});
  assign blank_c = 1'(active_mask >> idx);
  assign thr_c   = THR_W'(((32'(bright_q) + 32'd1) * SCAN_DIV) >> 4);

  seven_seg_decode u_decode (
    .nibble (nib_c),
    .seg_c  (seg_c)
  );

  // Next anode/cathode: dark on slot's first cycle and for blanked digits; PWM window follows it
  always_comb begin
    an_nxt      = '1;
    cathode_nxt = SEG_OFF;
    if ((presc != '0) && !blank_c) begin
      cathode_nxt = seg_c & {dp_bit_c, 7'h7F};
      if ({1'b0, presc} <= thr_c) an_nxt = ~(N_DIGITS'(1) << idx);
    end
  end

  // Registered pin outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an      <= '1;
      cathode <= SEG_OFF;
    end else begin
      an      <= an_nxt;
      cathode <= cathode_nxt;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench for seven_seg_scan_driver (N_DIGITS=4, SCAN_DIV=16).
// Expected lit cycles are queued per frame; a monitor pops one per lit sample.
module tb_seven_seg_scan_driver;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] cath;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] digits;
  logic [3:0]  blank_mask;
  logic [3:0]  brightness;
  logic [3:0]  an;
  logic [7:0]  cathode;
  logic        frame_start;
`ifdef SEVSEG_DP_EN
  logic [3:0]  dp;
`endif

  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  exp_t exp_q[$];

  seven_seg_scan_driver #(
    .N_DIGITS (4),
    .SCAN_DIV (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .digits      (digits),
    .blank_mask  (blank_mask),
`ifdef SEVSEG_DP_EN
    .dp          (dp),
`endif
    .brightness  (brightness),
    .an          (an),
    .cathode     (cathode),
    .frame_start (frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hand-entered segment table
  function automatic logic [7:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  // Queue every lit cycle of one frame: slot s lit for min(b+1,15) cycles
  task automatic push_frame(input logic [15:0] d, input logic [3:0] m, input int b);
    exp_t e;
    int   lit;
    logic [3:0] one;
    one = 4'b0001;
    lit = (b + 1 > 15) ? 15 : b + 1;
    for (int s = 0; s < 4; s++) begin
      if (!m[s]) begin
        for (int k = 0; k < lit; k++) begin
          e.an   = ~(one << s);
          e.cath = seg_of(d[4*s +: 4]);
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic wait_frame(input int exp_n, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 200);
    checks++;
    if (!frame_start || n != exp_n) begin
      errors++;
      $display("FAIL %s: frame_start after %0d cycles expected %0d", name, n, exp_n);
    end
  endtask

  task automatic pulse_load(input logic [15:0] d, input logic [3:0] m);
    load       = 1'b1;
    digits     = d;
    blank_mask = m;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Monitor: every lit sample must match the next queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (mon_en && an != 4'hF) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_lit: an=%b cathode=%h with empty queue", an, cathode);
        end else begin
          e = exp_q.pop_front();
          if (an !== e.an || cathode !== e.cath) begin
            errors++;
            $display("FAIL scan: an=%b cathode=%h expected an=%b cathode=%h",
                     an, cathode, e.an, e.cath);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    rst_n      = 1'b0;
    load       = 1'b0;
    digits     = 16'h0000;
    blank_mask = 4'h0;
    brightness = 4'd15;
`ifdef SEVSEG_DP_EN
    dp         = 4'h0;
`endif
    repeat (3) @(negedge clk);
    check8("reset_an", {4'h0, an}, 8'h0F);
    check8("reset_cathode", cathode, 8'hFF);
    check8("reset_frame_start", {7'h0, frame_start}, 8'h00);
    rst_n = 1'b1;
    wait_frame(64, "first_frame");

    // Frame A: load 3210 (shown from frame B)
    pulse_load(16'h3210, 4'h0);
    wait_frame(63, "period_A");

    // Frame B: 3210 at full brightness; load FEDC for C
    mon_en = 1'b1;
    push_frame(16'h3210, 4'h0, 15);
    pulse_load(16'hFEDC, 4'h0);
    wait_frame(63, "period_B");

    // Frame C: FEDC at minimum brightness
    brightness = 4'd0;
    push_frame(16'hFEDC, 4'h0, 0);
    wait_frame(64, "period_C");

    // Frame D: FEDC at brightness 7; mid-frame load must not tear
    brightness = 4'd7;
    push_frame(16'hFEDC, 4'h0, 7);
    repeat (20) @(negedge clk);
    pulse_load(16'h5555, 4'h0);
    wait_frame(43, "period_D");

    // Frame E: 5555; two loads, last one wins
    brightness = 4'd15;
    push_frame(16'h5555, 4'h0, 15);
    repeat (5) @(negedge clk);
    pulse_load(16'h1111, 4'h0);
    repeat (24) @(negedge clk);
    pulse_load(16'h89AB, 4'b0100);
    wait_frame(33, "period_E");

    // Frame F: 89AB with digit 2 blanked; load in wrap cycle lands in G
    push_frame(16'h89AB, 4'b0100, 15);
    repeat (40) @(negedge clk);
    check8("blank_slot_an", {4'h0, an}, 8'h0F);
    check8("blank_slot_cathode", cathode, 8'hFF);
    repeat (23) @(negedge clk);
    load       = 1'b1;
    digits     = 16'h4567;
    blank_mask = 4'h0;
    @(negedge clk);
    load = 1'b0;
    check8("wrap_frame_start", {7'h0, frame_start}, 8'h01);

    // Frame G: direct checks, then reset in the middle of slot 3
    mon_en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d entries left expected 0", exp_q.size());
    end
    repeat (50) @(negedge clk);
    check8("wrap_load_an", {4'h0, an}, 8'h07);
    check8("wrap_load_cathode", cathode, 8'h99);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check8("midreset_an", {4'h0, an}, 8'h0F);
    check8("midreset_cathode", cathode, 8'hFF);
    check8("midreset_frame_start", {7'h0, frame_start}, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check8("restart_guard_an", {4'h0, an}, 8'h0F);
    @(negedge clk);
    check8("restart_slot0_an", {4'h0, an}, 8'h0E);
    check8("restart_slot0_cathode", cathode, 8'hC0);
    wait_frame(62, "restart_frame");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
